// File: rtl/i2c_byte_ctrl.sv
// Byte-level I2C master engine: optional START, one byte write or read with ACK, optional STOP.
// Drives open-drain SCL/SDA pads in 4-phase bit slots with clock stretching and arbitration detection.
module i2c_byte_ctrl #(
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      en_i,
  input  logic [PRESCALE_WIDTH-1:0] prescale_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_start_i,
  input  logic                      cmd_stop_i,
  input  logic                      cmd_write_i,
  input  logic                      cmd_read_i,
  input  logic                      cmd_ack_i,
  input  logic [7:0]                tx_data_i,
  output logic                      done_o,
  output logic [7:0]                rx_data_o,
  output logic                      rx_ack_o,
  output logic                      arb_lost_o,
  output logic                      busy_o,
  input  logic                      scl_pad_i,
  output logic                      scl_pad_o,
  output logic                      scl_padoen_o,
  input  logic                      sda_pad_i,
  output logic                      sda_pad_o,
  output logic                      sda_padoen_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WRITE, S_READ, S_STOP, S_DONE
  } state_t;

  function automatic state_t first_seg(input logic wr, input logic rd, input logic stop);
    if (wr)        return S_WRITE;
    else if (rd)   return S_READ;
    else if (stop) return S_STOP;
    else           return S_DONE;
  endfunction

  state_t                    state_q, state_d;
  logic [1:0]                phase_q, phase_d;
  logic [3:0]                bit_q, bit_d;
  logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;

  logic stop_q, wr_q, rd_q, ack_q, hold_q;
  logic [7:0] tx_q, rx_sh_q, rx_data_q;
  logic ack_sh_q, rx_ack_q, arb_lost_q, busy_q;
  logic scl_meta, scl_s, sda_meta, sda_s, sda_d;

  logic accept, active, last_bit, scl_rel, sda_rel, phase_end, arb;

  assign cmd_ready_o = en_i && (state_q == S_IDLE) && !rst_i;
  assign accept      = cmd_valid_i && cmd_ready_o;
  assign active      = (state_q == S_START) || (state_q == S_WRITE) ||
                       (state_q == S_READ)  || (state_q == S_STOP);
  assign last_bit    = (bit_q == 4'd8);

  // Line levels per segment and phase; between commands SCL stays low if the bus is still owned.
  always_comb begin
    scl_rel = 1'b1;
    sda_rel = 1'b1;
    unique case (state_q)
      S_START: begin
        scl_rel = (phase_q != 2'd3);
        sda_rel = (phase_q < 2'd2);
      end
      S_WRITE: begin
        scl_rel = (phase_q == 2'd1) || (phase_q == 2'd2);
        sda_rel = last_bit || tx_q[7];
      end
      S_READ: begin
        scl_rel = (phase_q == 2'd1) || (phase_q == 2'd2);
        sda_rel = !last_bit || ack_q;
      end
      S_STOP: begin
        scl_rel = (phase_q != 2'd0);
        sda_rel = (phase_q == 2'd3);
      end
      default: begin
        scl_rel = !hold_q;
        sda_rel = 1'b1;
      end
    endcase
  end

  assign phase_end = active && (cnt_q == '0) && (!scl_rel || scl_s);
  assign arb       = (state_q == S_WRITE) && (phase_q == 2'd2) && !last_bit && sda_rel && !sda_s;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    if (state_q == S_IDLE) begin
      if (accept) begin
        cnt_d   = prescale_i;
        phase_d = 2'd0;
        bit_d   = 4'd0;
        state_d = cmd_start_i ? S_START : first_seg(cmd_write_i, cmd_read_i, cmd_stop_i);
      end
    end else if (state_q == S_DONE) begin
      state_d = S_IDLE;
    end else if (arb) begin
      state_d = S_DONE;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - PRESCALE_WIDTH'(1);
    end else if (phase_end) begin
      cnt_d   = prescale_i;
      phase_d = phase_q + 2'd1;
      if (phase_q == 2'd3) begin
        unique case (state_q)
          S_START: state_d = first_seg(wr_q, rd_q, stop_q);
          S_WRITE, S_READ: begin
            if (last_bit) state_d = stop_q ? S_STOP : S_DONE;
            else          bit_d   = bit_q + 4'd1;
          end
          default: state_d = S_DONE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      phase_q    <= 2'd0;
      bit_q      <= 4'd0;
      cnt_q      <= '0;
      stop_q     <= 1'b0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      ack_q      <= 1'b0;
      hold_q     <= 1'b0;
      tx_q       <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      ack_sh_q   <= 1'b0;
      rx_ack_q   <= 1'b0;
      arb_lost_q <= 1'b0;
      busy_q     <= 1'b0;
      scl_meta   <= 1'b1;
      scl_s      <= 1'b1;
      sda_meta   <= 1'b1;
      sda_s      <= 1'b1;
      sda_d      <= 1'b1;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
      scl_meta <= scl_pad_i;
      scl_s    <= scl_meta;
      sda_meta <= sda_pad_i;
      sda_s    <= sda_meta;
      sda_d    <= sda_s;
      if (scl_s && sda_d && !sda_s)      busy_q <= 1'b1;
      else if (scl_s && !sda_d && sda_s) busy_q <= 1'b0;
      if (accept) begin
        stop_q     <= cmd_stop_i;
        wr_q       <= cmd_write_i;
        rd_q       <= cmd_read_i && !cmd_write_i;
        ack_q      <= cmd_ack_i;
        tx_q       <= tx_data_i;
        arb_lost_q <= 1'b0;
      end
      if (arb) begin
        arb_lost_q <= 1'b1;
        hold_q     <= 1'b0;
      end else if (phase_end) begin
        if (phase_q == 2'd2 && state_q == S_READ && !last_bit) rx_sh_q  <= {rx_sh_q[6:0], sda_s};
        if (phase_q == 2'd2 && state_q == S_WRITE && last_bit) ack_sh_q <= sda_s;
        if (phase_q == 2'd3 && state_q == S_WRITE)             tx_q     <= {tx_q[6:0], 1'b0};
        if (phase_q == 2'd3)                                   hold_q   <= (state_q != S_STOP);
        // Results are published on the edge that enters DONE so they change with done_o.
        if (state_d == S_DONE) begin
          if (rd_q) rx_data_q <= rx_sh_q;
          if (wr_q) rx_ack_q  <= ack_sh_q;
        end
      end
    end
  end

  assign done_o       = (state_q == S_DONE);
  assign rx_data_o    = rx_data_q;
  assign rx_ack_o     = rx_ack_q;
  assign arb_lost_o   = arb_lost_q;
  assign busy_o       = busy_q;
  assign scl_pad_o    = 1'b0;
  assign sda_pad_o    = 1'b0;
  assign scl_padoen_o = scl_rel;
  assign sda_padoen_o = sda_rel;

endmodule

// File: tb/tb_i2c_byte_ctrl.sv
// Directed bench for i2c_byte_ctrl: vector table of commands plus stretch, arbitration and reset sequences.
module tb_i2c_byte_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, cmd_valid, cmd_ready, cmd_start, cmd_stop, cmd_write, cmd_read, cmd_ack;
  logic [15:0] prescale;
  logic [7:0]  tx_data, rx_data;
  logic        done, rx_ack, arb_lost, busy;
  logic        scl_pad_i, scl_pad_o, scl_padoen, sda_pad_i, sda_pad_o, sda_padoen;
  logic        slave_sda = 1'b1, sda_force = 1'b0, scl_stretch = 1'b0;

  assign scl_pad_i = scl_padoen & !scl_stretch;
  assign sda_pad_i = sda_padoen & slave_sda & !sda_force;

  i2c_byte_ctrl #(.PRESCALE_WIDTH(16)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .prescale_i(prescale),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_start_i(cmd_start), .cmd_stop_i(cmd_stop), .cmd_write_i(cmd_write),
    .cmd_read_i(cmd_read), .cmd_ack_i(cmd_ack), .tx_data_i(tx_data),
    .done_o(done), .rx_data_o(rx_data), .rx_ack_o(rx_ack), .arb_lost_o(arb_lost), .busy_o(busy),
    .scl_pad_i(scl_pad_i), .scl_pad_o(scl_pad_o), .scl_padoen_o(scl_padoen),
    .sda_pad_i(sda_pad_i), .sda_pad_o(sda_pad_o), .sda_padoen_o(sda_padoen)
  );

  typedef struct {
    int start, stop, wr, rd, ack, tx, sbyte, sack, p, lat, rx, rxack, busy, arb;
  } vec_t;

  vec_t vecs[8];
  vec_t hv;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues one command; the bench slave drives SDA by phase position (valid while unstretched).
  task automatic run_cmd(input string tag, input vec_t v, input bit stretch_en,
                         input bit arb_en, input int rst_at);
    int k, len, base, ph, pp, bitph, b, sub, str_cnt, pulses, lat;
    bit byte_cmd, in_byte, done_seen;
    len = v.p + 1;
    base = (v.start != 0) ? 4 : 0;
    byte_cmd = (v.wr != 0) || (v.rd != 0);
    k = 0;
    while (!cmd_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({tag, " ready"}, 32'(cmd_ready), 32'd1);
    prescale  = 16'(v.p);
    cmd_start = (v.start != 0);
    cmd_stop  = (v.stop != 0);
    cmd_write = (v.wr != 0);
    cmd_read  = (v.rd != 0);
    cmd_ack   = (v.ack != 0);
    tx_data   = 8'(v.tx);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    k = 1;
    str_cnt = 0;
    done_seen = 1'b0;
    while (k <= 4000) begin
      if (k == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        check({tag, " rst scl_oen"}, 32'(scl_padoen), 32'd1);
        check({tag, " rst sda_oen"}, 32'(sda_padoen), 32'd1);
        check({tag, " rst done"},    32'(done),       32'd0);
        check({tag, " rst ready"},   32'(cmd_ready),  32'd0);
        check({tag, " rst rx_data"}, 32'(rx_data),    32'd0);
        check({tag, " rst rx_ack"},  32'(rx_ack),     32'd0);
        check({tag, " rst arb"},     32'(arb_lost),   32'd0);
        check({tag, " rst busy"},    32'(busy),       32'd0);
        rst = 1'b0;
        slave_sda = 1'b1;
        return;
      end
      if (done) begin
        done_seen = 1'b1;
        break;
      end
      ph = (k - 1) / len;
      pp = (k - 1) % len;
      bitph = ph - base;
      b = bitph / 4;
      sub = bitph % 4;
      in_byte = byte_cmd && bitph >= 0 && bitph < 36;
      if (in_byte && v.wr != 0)  slave_sda = !(b == 8 && v.sack == 0);
      else if (in_byte)          slave_sda = (b < 8) ? (((v.sbyte >> (7 - b)) & 1) != 0) : 1'b1;
      else                       slave_sda = 1'b1;
      if (str_cnt > 0) begin
        str_cnt--;
        if (str_cnt == 0) scl_stretch = 1'b0;
      end else if (stretch_en && in_byte && bitph == 13 && pp == 0) begin
        scl_stretch = 1'b1;
        str_cnt = v.p + 18;
      end
      if (arb_en && in_byte && bitph == 1 && pp == 0) sda_force = 1'b1;
      if (!stretch_en && in_byte && sub == 1 && pp == 1) begin
        if (v.wr != 0)
          check($sformatf("%s sda bit%0d", tag, b), 32'(sda_padoen),
                (b < 8) ? 32'((v.tx >> (7 - b)) & 1) : 32'd1);
        else
          check($sformatf("%s sda bit%0d", tag, b), 32'(sda_padoen),
                (b < 8) ? 32'd1 : 32'(v.ack));
      end
      if (v.start != 0 && k == 20) check({tag, " busy mid"}, 32'(busy), 32'd1);
      @(negedge clk);
      k++;
    end
    lat = done_seen ? k : -1;
    check({tag, " done latency"}, 32'(lat), 32'(v.lat));
    check({tag, " rx_data"}, 32'(rx_data), 32'(v.rx));
    check({tag, " rx_ack"}, 32'(rx_ack), 32'(v.rxack));
    check({tag, " arb_lost"}, 32'(arb_lost), 32'(v.arb));
    check({tag, " busy"}, 32'(busy), 32'(v.busy));
    slave_sda = 1'b1;
    if (arb_en) begin
      check({tag, " scl released"}, 32'(scl_padoen), 32'd1);
      check({tag, " sda released"}, 32'(sda_padoen), 32'd1);
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (done) pulses++;
      end
      check({tag, " extra done pulses"}, 32'(pulses), 32'd0);
      sda_force = 1'b0;
      repeat (4) @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          st sp wr rd ak tx     sbyte  sack p  lat  rx     rxack busy arb
    vecs[0] = '{1, 1, 1, 0, 0, 'hA5, 'h00,  0,   3, 177, 'h00,  0,    0,   0};
    vecs[1] = '{0, 0, 0, 1, 1, 'h00, 'h3C,  1,   3, 145, 'h3C,  0,    0,   0};
    vecs[2] = '{0, 0, 1, 0, 0, 'h00, 'h00,  1,   3, 145, 'h3C,  1,    0,   0};
    vecs[3] = '{0, 1, 0, 1, 0, 'h00, 'hC9,  1,   3, 161, 'hC9,  1,    0,   0};
    vecs[4] = '{1, 0, 0, 0, 0, 'h00, 'h00,  1,   3, 17,  'hC9,  1,    1,   0};
    vecs[5] = '{0, 1, 1, 1, 1, 'h5A, 'hFF,  0,   3, 161, 'hC9,  0,    0,   0};
    vecs[6] = '{0, 0, 0, 0, 0, 'h00, 'h00,  1,   3, 1,   'hC9,  0,    0,   0};
    vecs[7] = '{1, 1, 1, 0, 0, 'h96, 'h00,  0,   5, 265, 'hC9,  0,    0,   0};

    rst = 1'b1; en = 1'b1; cmd_valid = 1'b0; cmd_start = 1'b0; cmd_stop = 1'b0;
    cmd_write = 1'b0; cmd_read = 1'b0; cmd_ack = 1'b0; tx_data = '0; prescale = 16'd3;
    repeat (3) @(negedge clk);
    check("reset ready",   32'(cmd_ready),  32'd0);
    check("reset done",    32'(done),       32'd0);
    check("reset rx_data", 32'(rx_data),    32'd0);
    check("reset rx_ack",  32'(rx_ack),     32'd0);
    check("reset arb",     32'(arb_lost),   32'd0);
    check("reset busy",    32'(busy),       32'd0);
    check("reset scl_oen", 32'(scl_padoen), 32'd1);
    check("reset sda_oen", 32'(sda_padoen), 32'd1);
    check("reset scl_o",   32'(scl_pad_o),  32'd0);
    check("reset sda_o",   32'(sda_pad_o),  32'd0);
    rst = 1'b0;
    en = 1'b0;
    @(negedge clk);
    check("ready with en low", 32'(cmd_ready), 32'd0);
    en = 1'b1;
    @(negedge clk);
    check("ready with en high", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 8; i++) begin
      run_cmd($sformatf("v%0d", i), vecs[i], 1'b0, 1'b0, 0);
      repeat (3) @(negedge clk);
    end

    // SCL held low 20 extra cycles in bit 3 phase B; slave gives no ACK.
    hv = '{1, 1, 1, 0, 0, 'h55, 'h00, 1, 3, 197, 'hC9, 1, 0, 0};
    run_cmd("stretch", hv, 1'b1, 1'b0, 0);
    repeat (3) @(negedge clk);

    // External master pulls SDA low while our MSB (1) is released.
    hv = '{0, 0, 1, 0, 0, 'h80, 'h00, 1, 3, 10, 'hC9, 1, 1, 1};
    run_cmd("arb", hv, 1'b0, 1'b1, 0);

    hv = '{0, 1, 0, 0, 0, 'h00, 'h00, 1, 3, 17, 'hC9, 1, 0, 0};
    run_cmd("arb clear", hv, 1'b0, 1'b0, 0);
    repeat (3) @(negedge clk);

    // Reset during bit 4 phase B, then a clean write.
    hv = '{1, 1, 1, 0, 0, 'hF0, 'h00, 0, 3, 0, 'h00, 0, 0, 0};
    run_cmd("midreset", hv, 1'b0, 1'b0, 86);
    repeat (3) @(negedge clk);
    run_cmd("post reset", vecs[0], 1'b0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
